// File: rtl/score_display_pkg.sv
// Shared types and constants for the score/lives display path.
// Used by the binary-to-BCD converter and its per-digit add-3 cell.
package score_display_pkg;

  localparam int BCD_W          = 4;
  localparam int DEFAULT_BIN_W  = 16;
  localparam int DEFAULT_DIGITS = 5;

  localparam logic [3:0] BCD_NINE = 4'h9;

  typedef enum logic {
    ST_IDLE,
    ST_SHIFT
  } state_t;

endpackage

// File: rtl/bcd_digit_adj.sv
// Single-digit correction step of shift-add-3: a digit of 5 or more gets +3 so that
// the following left shift carries correctly into the next decimal digit.
module bcd_digit_adj
  import score_display_pkg::*;
(
  input  logic [BCD_W-1:0] digit,
  output logic [BCD_W-1:0] adj
);

  // Largest input is 9 in valid BCD, so the result never exceeds 12 and fits in 4 bits.
  assign adj = (digit >= 4'd5) ? (digit + 4'd3) : digit;

endmodule

// File: rtl/score_bcd_converter.sv
// Sequential binary-to-BCD converter (shift-add-3, one input bit per clock) for the
// score display. Results are registered and held until the next conversion completes.
module score_bcd_converter
  import score_display_pkg::*;
#(
  parameter int BIN_W  = DEFAULT_BIN_W,
  parameter int DIGITS = DEFAULT_DIGITS
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [BIN_W-1:0]        bin,
  output logic                    busy,
  output logic                    done,
  output logic [BCD_W*DIGITS-1:0] bcd,
  output logic                    overflow
);

  localparam int BCD_TOT = BCD_W * DIGITS;
  localparam int CNT_W   = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

  // Handshake: start is taken only on an edge where busy=0; bin is sampled on that
  // edge alone. busy stays high for BIN_W cycles, then done pulses for one cycle
  // as bcd/overflow update. start during busy is dropped, never queued.

  state_t               state;
  state_t               state_next;
  logic [CNT_W-1:0]     count;
  logic [CNT_W-1:0]     count_next;
  logic [BIN_W-1:0]     shift_reg;
  logic [BIN_W-1:0]     shift_next;
  logic [BCD_TOT-1:0]   work;
  logic [BCD_TOT-1:0]   work_adj;
  logic [BCD_TOT-1:0]   work_next;
  logic                 ovf_work;
  logic                 ovf_next;
  logic [BCD_TOT-1:0]   bcd_next;
  logic                 overflow_next;
  logic                 done_next;

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_adj
      bcd_digit_adj u_adj (
        .digit (work[g*BCD_W +: BCD_W]),
        .adj   (work_adj[g*BCD_W +: BCD_W])
      );
    end
  endgenerate

  always_comb begin
    state_next    = state;
    count_next    = count;
    shift_next    = shift_reg;
    work_next     = work;
    ovf_next      = ovf_work;
    bcd_next      = bcd;
    overflow_next = overflow;
    done_next     = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_SHIFT;
          shift_next = bin;
          work_next  = '0;
          count_next = '0;
          ovf_next   = 1'b0;
        end
      end

      ST_SHIFT: begin
        // Anything leaving the top digit means the value needs more digits than we have.
        ovf_next   = ovf_work | work_adj[BCD_TOT-1];
        work_next  = {work_adj[BCD_TOT-2:0], shift_reg[BIN_W-1]};
        shift_next = {shift_reg[BIN_W-2:0], 1'b0};
        count_next = count + 1'b1;
        if (count == CNT_LAST) begin
          state_next    = ST_IDLE;
          done_next     = 1'b1;
          overflow_next = ovf_next;
          bcd_next      = ovf_next ? {DIGITS{BCD_NINE}} : work_next;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      count     <= '0;
      shift_reg <= '0;
      work      <= '0;
      ovf_work  <= 1'b0;
      bcd       <= '0;
      overflow  <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_next;
      count     <= count_next;
      shift_reg <= shift_next;
      work      <= work_next;
      ovf_work  <= ovf_next;
      bcd       <= bcd_next;
      overflow  <= overflow_next;
      done      <= done_next;
    end
  end

  assign busy = (state == ST_SHIFT);

endmodule

// File: tb/tb_score_bcd_converter.sv
// Directed bench for score_bcd_converter: a 5-digit and a 4-digit instance, with
// expected results queued at stimulus time and compared when done pulses.
module tb_score_bcd_converter;

  localparam int BIN_W    = 16;
  localparam int DIGITS   = 5;
  localparam int DIGITS_S = 4;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic                    start = 1'b0;
  logic [BIN_W-1:0]        bin   = '0;
  logic                    busy, done, overflow;
  logic [4*DIGITS-1:0]     bcd;

  logic                    start_s = 1'b0;
  logic [BIN_W-1:0]        bin_s   = '0;
  logic                    busy_s, done_s, overflow_s;
  logic [4*DIGITS_S-1:0]   bcd_s;

  score_bcd_converter #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk(clk), .reset(reset), .start(start), .bin(bin),
    .busy(busy), .done(done), .bcd(bcd), .overflow(overflow)
  );

  score_bcd_converter #(.BIN_W(BIN_W), .DIGITS(DIGITS_S)) dut_s (
    .clk(clk), .reset(reset), .start(start_s), .bin(bin_s),
    .busy(busy_s), .done(done_s), .bcd(bcd_s), .overflow(overflow_s)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  logic [20:0] exp_q[$];    // {overflow, bcd}
  logic [20:0] exp_s_q[$];

  int   done_cnt   = 0;
  int   done_s_cnt = 0;
  int   accept_cyc = 0;
  int   busy_run   = 0;
  logic prev_busy  = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: decimal digits by division, saturated to all nines past 10^nd-1.
  function automatic logic [20:0] model(input int v, input int nd);
    logic [20:0] r;
    int p;
    int x;
    r = '0;
    p = 1;
    for (int i = 0; i < nd; i++) p = p * 10;
    if (v >= p) begin
      for (int i = 0; i < nd; i++) r[i*4 +: 4] = 4'h9;
      r[20] = 1'b1;
    end else begin
      x = v;
      for (int i = 0; i < nd; i++) begin
        r[i*4 +: 4] = 4'(x % 10);
        x = x / 10;
      end
    end
    return r;
  endfunction

  always @(negedge clk) begin
    logic [20:0] e;
    if (reset) begin
      prev_busy = 1'b0;
      busy_run  = 0;
    end else begin
      if (busy && !prev_busy) accept_cyc = cyc;
      if (busy) busy_run++;
      if (done) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          check("spurious_done", 32'(done), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("bcd", 32'(bcd), 32'(e[19:0]));
          check("overflow", 32'(overflow), 32'(e[20]));
          check("latency", 32'(cyc - accept_cyc), 32'd16);
          check("busy_cycles", 32'(busy_run), 32'd16);
        end
        busy_run = 0;
      end
      prev_busy = busy;
    end
  end

  always @(negedge clk) begin
    logic [20:0] e;
    if (!reset && done_s) begin
      done_s_cnt++;
      if (exp_s_q.size() == 0) begin
        check("spurious_done_s", 32'(done_s), 32'd0);
      end else begin
        e = exp_s_q.pop_front();
        check("bcd_s", 32'(bcd_s), 32'(e[15:0]));
        check("overflow_s", 32'(overflow_s), 32'(e[20]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [BIN_W-1:0] v, input bit push);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("idle_timeout", 32'(busy), 32'd0);
    start = 1'b1;
    bin   = v;
    if (push) exp_q.push_back(model(int'(v), DIGITS));
    @(negedge clk);
    start = 1'b0;
    bin   = BIN_W'($urandom_range(0, 65535));
  endtask

  task automatic drive_s(input logic [BIN_W-1:0] v);
    int n;
    n = 0;
    @(negedge clk);
    while (busy_s && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("idle_timeout_s", 32'(busy_s), 32'd0);
    start_s = 1'b1;
    bin_s   = v;
    exp_s_q.push_back(model(int'(v), DIGITS_S));
    @(negedge clk);
    start_s = 1'b0;
    bin_s   = BIN_W'($urandom_range(0, 65535));
  endtask

  task automatic wait_done(input int target);
    int n;
    n = 0;
    while (done_cnt < target && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("done_count", 32'(done_cnt), 32'(target));
  endtask

  task automatic wait_done_s(input int target);
    int n;
    n = 0;
    while (done_s_cnt < target && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("done_count_s", 32'(done_s_cnt), 32'(target));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int base;
    int n;

    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_bcd", 32'(bcd), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    reset = 1'b0;

    // Zero, typical and maximum inputs.
    drive(16'd0, 1);
    wait_done(1);
    drive(16'd1234, 1);
    wait_done(2);
    drive(16'd65535, 1);
    wait_done(3);

    // Narrow instance: saturation on overflow, then clean recovery.
    drive_s(16'd12345);
    wait_done_s(1);
    drive_s(16'd42);
    wait_done_s(2);
    drive_s(16'd9999);
    wait_done_s(3);

    // start held through busy with a different bin must be ignored.
    base = done_cnt;
    drive(16'd1111, 1);
    start = 1'b1;
    bin   = 16'd999;
    repeat (10) @(negedge clk);
    start = 1'b0;
    wait_done(base + 1);
    repeat (20) @(negedge clk);
    check("ignored_start_done_cnt", 32'(done_cnt), 32'(base + 1));
    check("ignored_start_busy", 32'(busy), 32'd0);

    // Reset in the middle of a conversion discards it.
    base = done_cnt;
    drive(16'd4321, 0);
    repeat (6) @(negedge clk);
    check("pre_reset_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_bcd", 32'(bcd), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("no_done_after_reset", 32'(done_cnt), 32'(base));
    drive(16'd500, 1);
    wait_done(base + 1);

    // Back-to-back: next start issued in the done cycle.
    base = done_cnt;
    drive(16'd77, 1);
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("b2b_first_done", 32'(done), 32'd1);
    start = 1'b1;
    bin   = 16'd88;
    exp_q.push_back(model(88, DIGITS));
    @(negedge clk);
    start = 1'b0;
    check("b2b_accepted", 32'(busy), 32'd1);
    repeat (14) begin
      check("b2b_hold_77", 32'(bcd), 32'h00077);
      @(negedge clk);
    end
    wait_done(base + 2);
    check("b2b_final_bcd", 32'(bcd), 32'h00088);

    // A few random values through the scoreboard.
    for (int i = 0; i < 4; i++) begin
      drive(BIN_W'($urandom_range(0, 65535)), 1);
    end
    wait_done(base + 6);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("queue_s_drained", 32'(exp_s_q.size()), 32'd0);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
